pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32IM pipeline. Arbitrates four stall/flush sources: data-memory wait, taken branch/jump resolved in EX, multi-cycle M-extension ops in EX, and load-use bubble requests from the hazard unit. Drives every pipeline-register write enable, bubble and flush control, plus a stall performance counter. Sits beside the hazard handling unit, between the hazard detectors and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_stall_controller_if.sv | 35 +++
 rtl/pipeline_stall_controller.sv | 134 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the hazard detectors and the stall/flush sequencer.
// The sequencer uses the slave modport; the driving side uses master.
interface pipeline_stall_controller_if;
  logic        dmem_busy;
  logic        branch_taken;
  logic        muldiv_start;
  logic        muldiv_is_div;
  logic        load_use_hazard;
  logic        pc_write_en;
  logic        if_id_write_en;
  logic        id_ex_write_en;
  logic        ex_mem_write_en;
  logic        id_ex_bubble;
  logic        ex_mem_bubble;
  logic        mem_wb_bubble;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        muldiv_busy;
  logic [1:0]  state_out;
  logic [31:0] stall_count;

  modport master (
    output dmem_busy, branch_taken, muldiv_start, muldiv_is_div, load_use_hazard,
    input  pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
    input  id_ex_bubble, ex_mem_bubble, mem_wb_bubble, if_id_flush, id_ex_flush,
    input  muldiv_busy, state_out, stall_count
  );

  modport slave (
    input  dmem_busy, branch_taken, muldiv_start, muldiv_is_div, load_use_hazard,
    output pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
    output id_ex_bubble, ex_mem_bubble, mem_wb_bubble, if_id_flush, id_ex_flush,
    output muldiv_busy, state_out, stall_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage RV32IM pipeline: arbitrates
// dmem wait, branch redirect, multi-cycle M-ops and load-use bubbles.
module pipeline_stall_controller #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input logic clk,
  input logic reset,
  pipeline_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MULDIV    = 2'd2
  } state_t;

  // Counter preload is N-2: the first stall cycle happens while still in RUN.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);
  localparam bit         MUL_LONG = (MUL_CYCLES >= 2);
  localparam bit         DIV_LONG = (DIV_CYCLES >= 2);

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic [5:0]  cnt_nx;
  logic [31:0] stall_cnt;

  logic pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic id_ex_bub, ex_mem_bub, mem_wb_bub;
  logic if_id_fl, id_ex_fl;
  logic busy;

  always_comb begin
    pc_we      = 1'b1;
    if_id_we   = 1'b1;
    id_ex_we   = 1'b1;
    ex_mem_we  = 1'b1;
    id_ex_bub  = 1'b0;
    ex_mem_bub = 1'b0;
    mem_wb_bub = 1'b0;
    if_id_fl   = 1'b0;
    id_ex_fl   = 1'b0;
    busy       = 1'b0;
    state_nx   = state;
    cnt_nx     = cnt;

    if (reset) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      state_nx  = RUN;
      cnt_nx    = '0;
    end else if (bus.dmem_busy) begin
      // Full freeze: everything holds, only MEM/WB receives a NOP.
      pc_we      = 1'b0;
      if_id_we   = 1'b0;
      id_ex_we   = 1'b0;
      ex_mem_we  = 1'b0;
      mem_wb_bub = 1'b1;
      busy       = (state == MULDIV);
    end else begin
      case (state)
        RUN: begin
          if (bus.branch_taken) begin
            if_id_fl = 1'b1;
            id_ex_fl = 1'b1;
          end else if (bus.muldiv_start) begin
            if (bus.muldiv_is_div ? DIV_LONG : MUL_LONG) begin
              pc_we      = 1'b0;
              if_id_we   = 1'b0;
              id_ex_we   = 1'b0;
              ex_mem_bub = 1'b1;
              busy       = 1'b1;
              cnt_nx     = bus.muldiv_is_div ? DIV_LOAD : MUL_LOAD;
              state_nx   = MULDIV;
            end
          end else if (bus.load_use_hazard) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_bub = 1'b1;
            state_nx  = LU_BUBBLE;
          end
        end
        LU_BUBBLE: begin
          // A lagging load_use_hazard must not insert a second bubble.
          if (bus.branch_taken) begin
            if_id_fl = 1'b1;
            id_ex_fl = 1'b1;
          end
          state_nx = RUN;
        end
        MULDIV: begin
          if (cnt != '0) begin
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            id_ex_we   = 1'b0;
            ex_mem_bub = 1'b1;
            busy       = 1'b1;
            cnt_nx     = cnt - 6'd1;
          end else begin
            state_nx = RUN;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state <= state_nx;
    cnt   <= cnt_nx;
    if (reset)
      stall_cnt <= '0;
    else if (!pc_we)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.pc_write_en     = pc_we;
  assign bus.if_id_write_en  = if_id_we;
  assign bus.id_ex_write_en  = id_ex_we;
  assign bus.ex_mem_write_en = ex_mem_we;
  assign bus.id_ex_bubble    = id_ex_bub;
  assign bus.ex_mem_bubble   = ex_mem_bub;
  assign bus.mem_wb_bubble   = mem_wb_bub;
  assign bus.if_id_flush     = if_id_fl;
  assign bus.id_ex_flush     = id_ex_fl;
  assign bus.muldiv_busy     = busy;
  assign bus.state_out       = state;
  assign bus.stall_count     = stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed vectors push hand-derived
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_stall_controller_if bus();

  pipeline_stall_controller #(.MUL_CYCLES(4), .DIV_CYCLES(33)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Control pattern bit order: {pc, if_id, id_ex, ex_mem, id_ex_bub, ex_mem_bub, mem_wb_bub, if_id_fl, id_ex_fl}
  localparam logic [8:0] C_RST = 9'b0000_000_00;
  localparam logic [8:0] C_DEF = 9'b1111_000_00;
  localparam logic [8:0] C_DMB = 9'b0000_001_00;
  localparam logic [8:0] C_FLS = 9'b1111_000_11;
  localparam logic [8:0] C_MD  = 9'b0001_010_00;
  localparam logic [8:0] C_LU  = 9'b0011_100_00;

  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic        busy;
    logic [1:0]  st;
    logic [31:0] sc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_sc = '0;
  logic [8:0]  act_ctl;

  assign act_ctl = {bus.pc_write_en, bus.if_id_write_en, bus.id_ex_write_en, bus.ex_mem_write_en,
                    bus.id_ex_bubble, bus.ex_mem_bubble, bus.mem_wb_bubble,
                    bus.if_id_flush, bus.id_ex_flush};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_chk++;
      if ({act_ctl, bus.muldiv_busy, bus.state_out, bus.stall_count} !==
          {mon_e.ctl, mon_e.busy, mon_e.st, mon_e.sc}) begin
        n_fail++;
        $display("FAIL %s: got ctl=%b busy=%b state=%0d sc=%h, expected ctl=%b busy=%b state=%0d sc=%h",
                 mon_e.name, act_ctl, bus.muldiv_busy, bus.state_out, bus.stall_count,
                 mon_e.ctl, mon_e.busy, mon_e.st, mon_e.sc);
      end
    end
  end

  task automatic vec(input string name, input bit rst, input bit db, input bit bt,
                     input bit ms, input bit dv, input bit lu,
                     input logic [8:0] ctl, input logic busy, input logic [1:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    reset               = rst;
    bus.dmem_busy       = db;
    bus.branch_taken    = bt;
    bus.muldiv_start    = ms;
    bus.muldiv_is_div   = dv;
    bus.load_use_hazard = lu;
    e.name = name;
    e.ctl  = ctl;
    e.busy = busy;
    e.st   = st;
    e.sc   = exp_sc;
    q.push_back(e);
    if (rst) exp_sc = '0;
    else if (!ctl[8]) exp_sc = exp_sc + 32'd1;
  endtask

  task automatic idle(input string name, input logic [1:0] st);
    vec(name, 0, 0, 0, 0, 0, 0, C_DEF, 1'b0, st);
  endtask

  initial begin
    reset               = 1'b1;
    bus.dmem_busy       = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.muldiv_start    = 1'b0;
    bus.muldiv_is_div   = 1'b0;
    bus.load_use_hazard = 1'b0;
    @(posedge clk);

    vec("reset", 1, 0, 0, 0, 0, 0, C_RST, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) idle("idle", 2'd0);

    // DIV of 33 cycles: 32 stalls then release
    vec("div_start", 0, 0, 0, 1, 1, 0, C_MD, 1'b1, 2'd0);
    for (int i = 0; i < 31; i++) vec("div_stall", 0, 0, 0, 0, 0, 0, C_MD, 1'b1, 2'd2);
    idle("div_release", 2'd2);
    idle("div_done", 2'd0);
    idle("div_count", 2'd0);

    // load-use held two cycles gives a single bubble
    vec("lu_bubble", 0, 0, 0, 0, 0, 1, C_LU, 1'b0, 2'd0);
    vec("lu_lag_ignored", 0, 0, 0, 0, 0, 1, C_DEF, 1'b0, 2'd1);
    idle("lu_after", 2'd0);

    // branch beats load-use
    vec("br_over_lu", 0, 0, 1, 0, 0, 1, C_FLS, 1'b0, 2'd0);
    idle("br_after", 2'd0);

    // branch honoured inside LU_BUBBLE
    vec("lu_then_br", 0, 0, 0, 0, 0, 1, C_LU, 1'b0, 2'd0);
    vec("br_in_lub", 0, 0, 1, 0, 0, 0, C_FLS, 1'b0, 2'd1);
    idle("br_in_lub_after", 2'd0);

    // dmem_busy in RUN overrides branch
    vec("dmem_over_br", 0, 1, 1, 0, 0, 0, C_DMB, 1'b0, 2'd0);
    idle("dmem_after", 2'd0);

    // MUL of 4 cycles with a 3-cycle dmem freeze at counter=1
    vec("mul_start", 0, 0, 0, 1, 0, 0, C_MD, 1'b1, 2'd0);
    vec("mul_stall2", 0, 0, 0, 0, 0, 0, C_MD, 1'b1, 2'd2);
    for (int i = 0; i < 3; i++) vec("mul_dmem", 0, 1, 1, 1, 0, 1, C_DMB, 1'b1, 2'd2);
    vec("mul_stall1", 0, 0, 1, 1, 0, 1, C_MD, 1'b1, 2'd2);
    idle("mul_release", 2'd2);
    idle("mul_done", 2'd0);

    // stall_count wrap
    @(posedge clk);
    #1;
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    exp_sc = 32'hFFFF_FFFF;
    idle("sc_preset", 2'd0);
    vec("sc_wrap_stall", 0, 0, 0, 0, 0, 1, C_LU, 1'b0, 2'd0);
    idle("sc_wrapped", 2'd1);
    idle("sc_wrapped_hold", 2'd0);

    // reset mid-MULDIV
    vec("rm_start", 0, 0, 0, 1, 0, 0, C_MD, 1'b1, 2'd0);
    vec("rm_stall", 0, 0, 0, 0, 0, 0, C_MD, 1'b1, 2'd2);
    vec("rm_reset", 1, 0, 0, 0, 0, 0, C_RST, 1'b0, 2'd2);
    idle("rm_after", 2'd0);
    idle("rm_after2", 2'd0);

    // reset in LU_BUBBLE
    vec("rl_bubble", 0, 0, 0, 0, 0, 1, C_LU, 1'b0, 2'd0);
    vec("rl_reset", 1, 0, 0, 0, 0, 1, C_RST, 1'b0, 2'd1);
    idle("rl_after", 2'd0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
